// File: rtl/seq_shifter8.sv
// Serial shifter: one bit position per clock, with a valid/ready handshake on
// both the request and the result side. It takes the same operands as the
// combinational 8-bit barrel shifter, so it can stand in for it where latency
// is acceptable or serve as a cycle-accurate reference path.
//
// state  | meaning
// -------+------------------------------------------------------------------
// IDLE   | waiting for a request; in_ready=1
// SHIFT  | moving the operand one bit per cycle; cnt holds remaining shifts
// DONE   | result held on dout with out_valid=1 until out_ready
module seq_shifter8 #(
  parameter int W  = 8,
  parameter int SW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  din,
  input  logic [SW-1:0] shamt,
  input  logic          LR,
  input  logic          AL,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  dout,
  output logic          busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [W-1:0]  data_q;
  logic [SW-1:0] cnt_q;
  logic          lr_q;
  logic          fill_q;
  logic          accept;
  logic          last_shift;

  assign accept = in_valid && (state_q == S_IDLE);
  // cnt is never 0 inside SHIFT, but treating 0 as "last" keeps the FSM from
  // sticking if it ever were.
  assign last_shift = (cnt_q <= SW'(1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = (shamt == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (last_shift) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operand capture on accept, then one-bit shift and count-down per SHIFT cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      cnt_q  <= '0;
      lr_q   <= 1'b0;
      fill_q <= 1'b0;
    end else if (accept) begin
      data_q <= din;
      cnt_q  <= shamt;
      lr_q   <= LR;
      // Sign bit is captured once so the arithmetic fill cannot drift while
      // the register shifts underneath it.
      fill_q <= AL & din[W-1];
    end else if ((state_q == S_SHIFT) && (cnt_q != '0)) begin
      if (lr_q) begin
        data_q <= {data_q[W-2:0], 1'b0};
      end else begin
        data_q <= {fill_q, data_q[W-1:1]};
      end
      cnt_q <= cnt_q - SW'(1);
    end
  end

  // Outputs decoded from state; dout always shows the working register
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    busy      = (state_q == S_SHIFT) || (state_q == S_DONE);
    dout      = data_q;
  end

endmodule

// File: tb/tb_seq_shifter8.sv
// Directed bench for seq_shifter8: hand-computed results and latencies, plus a
// sweep compared against a barrel-shifter reference function.
module tb_seq_shifter8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] din;
  logic [2:0] shamt;
  logic       LR;
  logic       AL;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] dout;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_shifter8 #(.W(8), .SW(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .shamt     (shamt),
    .LR        (LR),
    .AL        (AL),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .busy      (busy)
  );

  function automatic logic [7:0] barrel(input logic [7:0] d, input logic [2:0] s,
                                        input logic lr, input logic al);
    logic signed [7:0] sd;
    logic [7:0] r;
    sd = d;
    if (lr) r = d << s;
    else if (al) r = 8'(sd >>> s);
    else r = d >> s;
    return r;
  endfunction

  // Drives one request, then waits (bounded) for out_valid. lat counts clock
  // edges from the accept edge (accept edge = 1). Returns at the negedge where
  // out_valid was first seen. With noise set, inputs are scrambled while busy.
  task automatic issue_op(input logic [7:0] d, input logic [2:0] s, input logic lr,
                          input logic al, input bit noise,
                          output logic [7:0] res, output int lat);
    @(negedge clk);
    in_valid = 1'b1; din = d; shamt = s; LR = lr; AL = al;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (noise) begin
        in_valid = 1'b1;
        din      = 8'($urandom);
        shamt    = 3'($urandom);
        LR       = 1'($urandom);
        AL       = 1'($urandom);
      end else begin
        in_valid = 1'b0;
      end
    end while (!out_valid && lat < 40);
    in_valid = 1'b0;
    res = dout;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; in_valid = 1'b0; din = '0; shamt = '0; LR = 1'b0; AL = 1'b0;
    out_ready = 1'b1;
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout got=%h exp=00", dout); end
    rst_n = 1'b1;
  endtask

  task automatic test_arith_right();
    logic [7:0] r; int lat;
    issue_op(8'hB4, 3'd3, 1'b0, 1'b1, 1'b0, r, lat);
    n_checks++; if (r !== 8'hF6) begin n_fail++; $display("FAIL asr_dout got=%h exp=f6", r); end
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL asr_latency got=%0d exp=4", lat); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL asr_busy_done got=%b exp=1", busy); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL asr_in_ready_done got=%b exp=0", in_ready); end
  endtask

  task automatic test_logical_right();
    logic [7:0] r; int lat;
    issue_op(8'hB4, 3'd3, 1'b0, 1'b0, 1'b0, r, lat);
    n_checks++; if (r !== 8'h16) begin n_fail++; $display("FAIL lsr_dout got=%h exp=16", r); end
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL lsr_latency got=%0d exp=4", lat); end
  endtask

  task automatic test_left_and_max();
    logic [7:0] r; int lat;
    issue_op(8'h81, 3'd1, 1'b1, 1'b1, 1'b0, r, lat);
    n_checks++; if (r !== 8'h02) begin n_fail++; $display("FAIL left_al_dout got=%h exp=02", r); end
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL left_al_latency got=%0d exp=2", lat); end
    issue_op(8'h80, 3'd7, 1'b0, 1'b1, 1'b0, r, lat);
    n_checks++; if (r !== 8'hFF) begin n_fail++; $display("FAIL max_asr_dout got=%h exp=ff", r); end
    n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL max_asr_latency got=%0d exp=8", lat); end
  endtask

  task automatic test_zero_shift();
    logic [7:0] r; int lat;
    issue_op(8'h5A, 3'd0, 1'b0, 1'b0, 1'b0, r, lat);
    n_checks++; if (r !== 8'h5A) begin n_fail++; $display("FAIL zero_dout got=%h exp=5a", r); end
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL zero_latency got=%0d exp=1", lat); end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL zero_handoff_valid got=%b exp=0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL zero_handoff_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_backpressure();
    logic [7:0] r; int lat;
    out_ready = 1'b0;
    issue_op(8'hC3, 3'd2, 1'b1, 1'b0, 1'b0, r, lat);
    n_checks++; if (r !== 8'h0C) begin n_fail++; $display("FAIL bp_first_dout got=%h exp=0c", r); end
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL bp_first_latency got=%0d exp=3", lat); end
    in_valid = 1'b1; din = 8'h0F; shamt = 3'd1; LR = 1'b1; AL = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++; if (dout !== 8'h0C) begin n_fail++; $display("FAIL bp_hold_dout cyc=%0d got=%h exp=0c", i, dout); end
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid cyc=%0d got=%b exp=1", i, out_valid); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold_ready cyc=%0d got=%b exp=0", i, in_ready); end
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_idle_ready got=%b exp=1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_idle_valid got=%b exp=0", out_valid); end
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_pending_taken got=%b exp=1", busy); end
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    n_checks++; if (dout !== 8'h1E) begin n_fail++; $display("FAIL bp_second_dout got=%h exp=1e", dout); end
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL bp_second_latency got=%0d exp=2", lat); end
  endtask

  task automatic test_ignore_inputs();
    logic [7:0] r; int lat;
    issue_op(8'h81, 3'd4, 1'b0, 1'b1, 1'b1, r, lat);
    n_checks++; if (r !== 8'hF8) begin n_fail++; $display("FAIL ignore_dout got=%h exp=f8", r); end
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL ignore_latency got=%0d exp=5", lat); end
  endtask

  task automatic test_reset_mid_shift();
    logic [7:0] r; int lat;
    @(negedge clk);
    in_valid = 1'b1; din = 8'hB4; shamt = 3'd7; LR = 1'b0; AL = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre_busy got=%b exp=1", busy); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid got=%b exp=0", out_valid); end
    n_checks++; if (dout !== 8'h00) begin n_fail++; $display("FAIL rst_mid_dout got=%h exp=00", dout); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready got=%b exp=1", in_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    issue_op(8'h0F, 3'd2, 1'b1, 1'b0, 1'b0, r, lat);
    n_checks++; if (r !== 8'h3C) begin n_fail++; $display("FAIL rst_after_dout got=%h exp=3c", r); end
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL rst_after_latency got=%0d exp=3", lat); end
  endtask

  task automatic test_sweep();
    logic [7:0] r; int lat;
    logic [7:0] d; logic [2:0] s; logic lr; logic al; logic [7:0] e;
    logic [7:0] pats [2];
    pats[0] = 8'hB4;
    pats[1] = 8'h5A;
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < 32; k++) begin
        d = pats[p]; s = 3'(k); lr = k[3]; al = k[4];
        e = barrel(d, s, lr, al);
        issue_op(d, s, lr, al, 1'b0, r, lat);
        n_checks++; if (r !== e) begin n_fail++; $display("FAIL sweep_dout din=%h sh=%0d lr=%b al=%b got=%h exp=%h", d, s, lr, al, r, e); end
        n_checks++; if (lat !== int'(s) + 1) begin n_fail++; $display("FAIL sweep_latency sh=%0d got=%0d exp=%0d", s, lat, int'(s) + 1); end
      end
    end
    for (int k = 0; k < 150; k++) begin
      d = 8'($urandom); s = 3'($urandom); lr = 1'($urandom); al = 1'($urandom);
      e = barrel(d, s, lr, al);
      issue_op(d, s, lr, al, 1'b1, r, lat);
      n_checks++; if (r !== e) begin n_fail++; $display("FAIL rand_dout din=%h sh=%0d lr=%b al=%b got=%h exp=%h", d, s, lr, al, r, e); end
      n_checks++; if (lat !== int'(s) + 1) begin n_fail++; $display("FAIL rand_latency sh=%0d got=%0d exp=%0d", s, lat, int'(s) + 1); end
    end
  endtask

  initial begin
    test_reset();
    test_arith_right();
    test_logical_right();
    test_left_and_max();
    test_zero_shift();
    test_backpressure();
    test_ignore_inputs();
    test_reset_mid_shift();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
